// File: rtl/dm_access_ctrl_if.sv
// Bundle of pipeline request/response and data-memory bus signals for dm_access_ctrl.
// The master side is the pipeline plus memory environment; the slave side is the controller.
interface dm_access_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();
  // Pipeline request
  logic                  req_valid;
  logic                  req_we;
  logic [2:0]            req_op;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  req_ready;
  logic                  stall;
  // Pipeline response
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic [1:0]            rsp_exc;
  // Memory bus
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, stall, rsp_valid, rsp_rdata, rsp_exc,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, stall, rsp_valid, rsp_rdata, rsp_exc,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: aligned request generation, handshaked wait with
// timeout, and sign/zero extension of load data.
module dm_access_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic            clk,
  input logic            reset,
  dm_access_ctrl_if.slave bus
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q, state_d;

  // size is log2 of the access width in bytes
  logic [1:0]        size_d, size_q;
  logic              sign_d, sign_q;
  logic              we_q;
  logic [OFF_W-1:0]  off_d, off_q;
  logic              aligned;
  logic [NB-1:0]     lane_mask;
  logic [NB-1:0]     be_d, be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        exc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_hit;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;
  logic              msb;
  int                nbits;

  // Decode the incoming request: access size, signedness, alignment and byte enables.
  always_comb begin
    size_d = 2'd2;
    sign_d = 1'b1;
    case (bus.req_op)
      3'b001:  begin size_d = 2'd1; sign_d = 1'b1; end
      3'b010:  begin size_d = 2'd1; sign_d = 1'b0; end
      3'b011:  begin size_d = 2'd0; sign_d = 1'b1; end
      3'b100:  begin size_d = 2'd0; sign_d = 1'b0; end
      3'b101:  size_d = (DATA_W == 64) ? 2'd3 : 2'd2;
      default: size_d = 2'd2;
    endcase
    off_d = bus.req_addr[OFF_W-1:0];
    case (size_d)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~bus.req_addr[0];
      2'd2:    aligned = (bus.req_addr[1:0] == 2'b00);
      default: aligned = (bus.req_addr[2:0] == 3'b000);
    endcase
    lane_mask = NB'((32'd1 << (32'd1 << size_d)) - 32'd1);
    be_d      = bus.req_we ? (lane_mask << off_d) : {NB{1'b1}};
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.req_valid) state_d = aligned ? StWait : StResp;
      StWait:  if (bus.mem_ack || timeout_hit) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Request capture, wait-cycle counter and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      size_q  <= 2'd0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      off_q   <= '0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      exc_q   <= 2'b00;
      cnt_q   <= '0;
    end else if (state_q == StIdle && bus.req_valid) begin
      size_q  <= size_d;
      sign_q  <= sign_d;
      we_q    <= bus.req_we;
      off_q   <= off_d;
      be_q    <= be_d;
      addr_q  <= {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      wdata_q <= bus.req_wdata << {off_d, 3'b000};
      rdata_q <= '0;
      exc_q   <= aligned ? 2'b00 : (bus.req_we ? 2'b10 : 2'b01);
      cnt_q   <= '0;
    end else if (state_q == StWait) begin
      // An ack on the final counted cycle still wins over the timeout.
      if (bus.mem_ack) begin
        rdata_q <= bus.mem_rdata;
        exc_q   <= 2'b00;
      end else if (timeout_hit) begin
        exc_q   <= 2'b11;
      end else begin
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Load extraction and extension from the captured bus word.
  always_comb begin
    shifted = rdata_q >> {off_q, 3'b000};
    case (size_q)
      2'd0:    begin nbits = 8;  msb = shifted[7];  end
      2'd1:    begin nbits = 16; msb = shifted[15]; end
      2'd2:    begin nbits = 32; msb = shifted[31]; end
      default: begin nbits = int'(DATA_W); msb = 1'b0; end
    endcase
    ext = shifted;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i >= nbits) ext[i] = sign_q & msb;
    end
  end

  // Outputs are gated by state so that they read zero whenever not meaningful.
  assign bus.req_ready = (state_q == StIdle);
  assign bus.stall     = ((state_q == StIdle) && bus.req_valid) || (state_q == StWait);
  assign bus.mem_req   = (state_q == StWait);
  assign bus.mem_we    = (state_q == StWait) && we_q;
  assign bus.mem_addr  = (state_q == StWait) ? addr_q : '0;
  assign bus.mem_be    = (state_q == StWait) ? be_q : '0;
  assign bus.mem_wdata = (state_q == StWait) ? wdata_q : '0;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_exc   = (state_q == StResp) ? exc_q : 2'b00;
  assign bus.rsp_rdata = ((state_q == StResp) && exc_q == 2'b00 && !we_q) ? ext : '0;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench: a 32-bit and a 64-bit controller driven side by side, each
// compared cycle by cycle against a transaction-level reference model.
module tb_dm_access_ctrl;
  localparam int TO32 = 4;
  localparam int TO64 = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_access_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if32 ();
  dm_access_ctrl_if #(.DATA_W(64), .ADDR_W(32)) if64 ();

  dm_access_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO32)) dut32 (
    .clk(clk), .reset(reset), .bus(if32.slave)
  );
  dm_access_ctrl #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO64)) dut64 (
    .clk(clk), .reset(reset), .bus(if64.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Observed values, index 0 = 32-bit DUT, 1 = 64-bit DUT; ctrl = {mem_req,rsp_valid,stall,req_ready}
  logic [3:0]  o_ctrl[2];
  logic [63:0] o_rdata[2], o_wdata[2];
  logic [1:0]  o_exc[2];
  logic [31:0] o_addr[2];
  logic [7:0]  o_be[2];
  logic        o_we[2];

  // Expected values from the model
  int          e_resp[2];
  logic [1:0]  e_exc[2];
  logic [63:0] e_rdata[2], e_wdata[2];
  logic [31:0] e_addr[2];
  logic [7:0]  e_be[2];
  logic        e_we[2];

  task automatic sample();
    o_ctrl[0]  = {if32.mem_req, if32.rsp_valid, if32.stall, if32.req_ready};
    o_ctrl[1]  = {if64.mem_req, if64.rsp_valid, if64.stall, if64.req_ready};
    o_rdata[0] = {32'h0, if32.rsp_rdata};
    o_rdata[1] = if64.rsp_rdata;
    o_wdata[0] = {32'h0, if32.mem_wdata};
    o_wdata[1] = if64.mem_wdata;
    o_exc[0]   = if32.rsp_exc;
    o_exc[1]   = if64.rsp_exc;
    o_addr[0]  = if32.mem_addr;
    o_addr[1]  = if64.mem_addr;
    o_be[0]    = {4'h0, if32.mem_be};
    o_be[1]    = if64.mem_be;
    o_we[0]    = if32.mem_we;
    o_we[1]    = if64.mem_we;
  endtask

  task automatic drive_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [63:0] wdata);
    if32.req_we = we;  if32.req_op = op;  if32.req_addr = addr;  if32.req_wdata = wdata[31:0];
    if64.req_we = we;  if64.req_op = op;  if64.req_addr = addr;  if64.req_wdata = wdata;
  endtask

  task automatic drive_ack(input logic ack, input logic [63:0] rdata);
    if32.mem_ack = ack;  if32.mem_rdata = rdata[31:0];
    if64.mem_ack = ack;  if64.mem_rdata = rdata;
  endtask

  // Transaction-level reference: access size from op, alignment by modulo, lanes by offset.
  task automatic model(input int d, input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rdata, input int ack_k);
    int nb, to, size, off;
    bit sgn, aligned;
    longint unsigned wmask, v, fm;
    nb    = (d == 0) ? 4 : 8;
    to    = (d == 0) ? TO32 : TO64;
    wmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (op)
      3'd1, 3'd2: size = 2;
      3'd3, 3'd4: size = 1;
      3'd5:       size = (nb == 8) ? 8 : 4;
      default:    size = 4;
    endcase
    sgn     = !(op == 3'd2 || op == 3'd4);
    off     = int'(addr % nb);
    aligned = (addr % size) == 0;
    e_addr[d]  = addr - 32'(off);
    e_we[d]    = we;
    e_be[d]    = 8'(we ? (((1 << size) - 1) << off) : ((1 << nb) - 1));
    e_wdata[d] = ((wdata & wmask) << (8 * off)) & wmask;
    if (!aligned) begin
      e_resp[d] = 1;
      e_exc[d]  = we ? 2'b10 : 2'b01;
    end else if (ack_k >= 0 && ack_k <= to) begin
      e_resp[d] = 2 + ack_k;
      e_exc[d]  = 2'b00;
    end else begin
      e_resp[d] = 2 + to;
      e_exc[d]  = 2'b11;
    end
    e_rdata[d] = 64'h0;
    if (e_exc[d] == 2'b00 && !we) begin
      v = (rdata & wmask) >> (8 * off);
      if (size < 8) begin
        fm = (64'd1 << (8 * size)) - 64'd1;
        v  = v & fm;
        if (sgn && ((v >> (8 * size - 1)) & 64'd1) == 64'd1) v = v | ~fm;
      end
      e_rdata[d] = v & wmask;
    end
  endtask

  // Issue one request to both DUTs and check every cycle until both are idle again.
  // ack_k is the WAIT cycle index of the ack pulse, or -1 for never.
  task automatic run_txn(input string name, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int ack_k);
    int last;
    logic [3:0] exp_ctrl;
    model(0, we, op, addr, wdata, rdata, ack_k);
    model(1, we, op, addr, wdata, rdata, ack_k);
    last = (e_resp[0] > e_resp[1]) ? e_resp[0] : e_resp[1];
    @(negedge clk);
    drive_req(we, op, addr, wdata);
    drive_ack(1'b0, 64'h0);
    if32.req_valid = 1'b1;
    if64.req_valid = 1'b1;
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_ctrl[d] !== 4'b0011)
        $display("FAIL %s dut%0d accept ctrl: got %b expected %b", name, d, o_ctrl[d], 4'b0011);
      else n_pass++;
    end
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      drive_ack(c - 1 == ack_k, rdata);
      #1 sample();
      for (int d = 0; d < 2; d++) begin
        exp_ctrl = {c < e_resp[d], c == e_resp[d], c < e_resp[d], c > e_resp[d]};
        n_checks++;
        if (o_ctrl[d] !== exp_ctrl)
          $display("FAIL %s dut%0d cyc%0d ctrl: got %b expected %b", name, d, c, o_ctrl[d],
                   exp_ctrl);
        else n_pass++;
        if (c < e_resp[d]) begin
          n_checks++;
          if ({o_we[d], o_addr[d], o_be[d], o_wdata[d]} !==
              {e_we[d], e_addr[d], e_be[d], e_wdata[d]})
            $display("FAIL %s dut%0d cyc%0d mem we/addr/be/wdata: got %b %h %h %h expected %b %h %h %h",
                     name, d, c, o_we[d], o_addr[d], o_be[d], o_wdata[d],
                     e_we[d], e_addr[d], e_be[d], e_wdata[d]);
          else n_pass++;
        end
        if (c == e_resp[d]) begin
          n_checks++;
          if ({o_exc[d], o_rdata[d]} !== {e_exc[d], e_rdata[d]})
            $display("FAIL %s dut%0d rsp exc/rdata: got %b %h expected %b %h", name, d,
                     o_exc[d], o_rdata[d], e_exc[d], e_rdata[d]);
          else n_pass++;
          if (d == 0) if32.req_valid = 1'b0;
          else        if64.req_valid = 1'b0;
        end
      end
    end
    drive_ack(1'b0, 64'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_ctrl[d] !== 4'b0001)
        $display("FAIL reset dut%0d ctrl: got %b expected %b", d, o_ctrl[d], 4'b0001);
      else n_pass++;
      n_checks++;
      if ({o_exc[d], o_rdata[d], o_addr[d], o_be[d], o_wdata[d], o_we[d]} !== '0)
        $display("FAIL reset dut%0d outputs: got exc %b rdata %h addr %h be %h wdata %h we %b expected zero",
                 d, o_exc[d], o_rdata[d], o_addr[d], o_be[d], o_wdata[d], o_we[d]);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_load_half();
    run_txn("ld_half_signed", 1'b0, 3'b001, 32'h0000_1002, 64'h0, 64'h0000_0000_8001_1234, 0);
    run_txn("ld_half_unsigned", 1'b0, 3'b010, 32'h0000_1002, 64'h0, 64'h0000_0000_8001_1234, 1);
    run_txn("ld_word", 1'b0, 3'b000, 32'h0000_0004, 64'h0, 64'h8765_4321_9ABC_DEF0, 2);
  endtask

  task automatic test_store_byte();
    run_txn("st_byte", 1'b1, 3'b011, 32'h0000_0003, 64'h0000_0000_0000_00AB, 64'h0, 0);
    run_txn("st_half", 1'b1, 3'b001, 32'h0000_0006, 64'h0000_0000_0000_BEEF, 64'h0, 3);
  endtask

  task automatic test_misaligned();
    run_txn("ld_word_misaligned", 1'b0, 3'b000, 32'h0000_0006, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_txn("st_word_misaligned", 1'b1, 3'b000, 32'h0000_0006, 64'h1234_5678, 64'h0, 0);
    run_txn("ld_half_misaligned", 1'b0, 3'b001, 32'h0000_1001, 64'h0, 64'h0, 0);
    run_txn("ld_dw_at_4", 1'b0, 3'b101, 32'h0000_0014, 64'h0, 64'hCAFE_F00D_DEAD_BEEF, 1);
  endtask

  task automatic test_doubleword();
    run_txn("ld_dw", 1'b0, 3'b101, 32'h0000_0010, 64'h0, 64'h1122_3344_5566_7788, 5);
    run_txn("ld_byte_unsigned", 1'b0, 3'b100, 32'h0000_0017, 64'h0, 64'hC355_6677_8899_AABB, 1);
    run_txn("st_dw", 1'b1, 3'b101, 32'h0000_0028, 64'h0102_0304_0506_0708, 64'h0, 2);
  endtask

  task automatic test_timeout();
    run_txn("timeout_never_ack", 1'b0, 3'b000, 32'h0000_0040, 64'h0, 64'h0, -1);
    run_txn("ack_at_timeout", 1'b0, 3'b000, 32'h0000_0044, 64'h0, 64'h0000_0000_8000_0001, TO32);
    run_txn("after_timeout", 1'b0, 3'b011, 32'h0000_0001, 64'h0, 64'h0000_0000_0000_8000, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_req(1'b0, 3'b000, 32'h0000_0020, 64'h0);
    drive_ack(1'b0, 64'h0);
    if32.req_valid = 1'b1;
    if64.req_valid = 1'b1;
    @(negedge clk);
    #1 sample();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (o_ctrl[d] !== 4'b1010)
        $display("FAIL reset_mid dut%0d wait ctrl: got %b expected %b", d, o_ctrl[d], 4'b1010);
      else n_pass++;
    end
    reset = 1'b1;
    if32.req_valid = 1'b0;
    if64.req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      reset = 1'b0;
      // A stray ack while idle must not resurrect the abandoned access.
      drive_ack(c == 1, 64'h5555_5555_5555_5555);
      #1 sample();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (o_ctrl[d] !== 4'b0001)
          $display("FAIL reset_mid dut%0d cyc%0d ctrl: got %b expected %b", d, c, o_ctrl[d],
                   4'b0001);
        else n_pass++;
      end
    end
    drive_ack(1'b0, 64'h0);
    run_txn("after_reset", 1'b0, 3'b000, 32'h0000_0020, 64'h0, 64'h0000_0000_7FFF_0001, 1);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [63:0] wdata, rdata;
    for (int i = 0; i < 60; i++) begin
      addr  = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFF8;
      wdata = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      run_txn("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, wdata, rdata,
              int'($urandom_range(0, 11)) - 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    if32.req_valid = 1'b0;
    if64.req_valid = 1'b0;
    drive_req(1'b0, 3'b000, 32'h0, 64'h0);
    drive_ack(1'b0, 64'h0);
    test_reset();
    test_load_half();
    test_store_byte();
    test_misaligned();
    test_doubleword();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Data-memory access controller for the M stage of the pipelined CPU. It replaces the combinational load extender with a handshaked unit that does three jobs:
- generates aligned memory requests, byte enables and lane-shifted store data;
- waits a variable number of cycles for the memory acknowledge, stalling the pipeline meanwhile;
- returns sign- or zero-extended load data together with an exception code.

It is parametrised for a 32- or 64-bit data bus, adds doubleword access, detects misaligned addresses, and times out a hung bus.

## Interface
Parameters:
- DATA_W, 32, memory data bus width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum number of WAIT cycles before a bus error is reported; must be at least 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  M-stage instruction is a load or store. Held stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_op  in  3  access type:
  - 000 word; 001 half signed; 010 half unsigned; 011 byte signed; 100 byte unsigned.
  - 101 doubleword (DATA_W=64 only).
  - Ops 101 (when DATA_W=32), 110 and 111 are treated as word.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- req_ready  out  1  equals 1 only in IDLE.
- stall  out  1  pipeline freeze request.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data. 0 for stores and for any exception.
- rsp_exc  out  2  00 none, 01 AdEL, 10 AdES, 11 bus timeout.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  req_addr with its low log2(DATA_W/8) bits cleared.
- mem_be  out  DATA_W/8  byte enables; meaningful for stores, all-ones for loads.
- mem_wdata  out  DATA_W  store data shifted into its byte lanes.
- mem_ack  in  1  memory completion; sampled only in WAIT.
- mem_rdata  in  DATA_W  read data; valid in the same cycle as mem_ack.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request is accepted when req_valid=1.
  - On acceptance, op, we and the byte offset are registered, and mem_addr/mem_we/mem_be/mem_wdata are registered.
  - Next state is WAIT if the address is aligned; otherwise RESP with rsp_exc = AdEL (load) or AdES (store). A misaligned access issues no mem_req.
- Alignment rules:
  - word: addr[1:0]=0.
  - half: addr[0]=0.
  - doubleword: addr[2:0]=0.
  - byte: always aligned.
- Byte lane offset: off = addr[log2(DATA_W/8)-1:0]. Byte access uses lane off; half uses lanes off..off+1; word uses off..off+3.
- mem_wdata = req_wdata << (8*off). mem_be has ones exactly on the accessed lanes.
- WAIT:
  - mem_req=1 with all mem_* outputs stable.
  - On mem_ack=1, mem_rdata is captured and the FSM goes to RESP with rsp_exc=00.
  - A cycle counter starts at 0 on entry. If the counter reaches TIMEOUT with mem_ack still 0, the FSM goes to RESP with rsp_exc=11 and mem_req drops.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
- Load extension:
  - Extract the accessed lanes from the captured data starting at lane off.
  - Sign- or zero-extend to DATA_W per op.
  - Word on a 64-bit bus is sign-extended; doubleword is passed through unchanged.
- stall = (IDLE & req_valid) | WAIT. stall is 0 in RESP, so the pipeline advances on the RESP clock edge. The same instruction is never accepted twice because req_ready=0 in RESP.
- Reset, whether idle or mid-operation:
  - next state is IDLE and the counter is cleared;
  - every output is 0, except req_ready=1 (IDLE);
  - any abandoned access produces no rsp_valid.
- A mem_ack arriving outside WAIT is ignored.

## Timing
- Acceptance cycle is t. mem_req is first high at t+1.
- Earliest mem_ack is at t+1, giving rsp_valid at t+2. This is the minimum latency of 2 cycles.
- Ack at WAIT cycle k (k=0 is t+1) gives rsp_valid at t+2+k.
- Misaligned access: rsp_valid at t+1; mem_req stays 0 throughout.
- Timeout: mem_req is high for cycles t+1 .. t+1+TIMEOUT, and rsp_valid with rsp_exc=11 arrives at t+2+TIMEOUT.
- rsp_rdata and rsp_exc are valid only while rsp_valid=1. They hold at 0 otherwise.
- If the ack arrives exactly on the cycle the counter reaches TIMEOUT, the ack wins and rsp_exc=00.

## Test plan
- DATA_W=32, load half-signed from addr 0x1002, ack at once, mem_rdata=0x8001_1234 → rsp_rdata=0xFFFF_8001, rsp_exc=00, rsp_valid 2 cycles after acceptance.
- DATA_W=32, store byte 0xAB to 0x0003 → mem_be=4'b1000, mem_wdata=0xAB00_0000, mem_addr=0x0000.
- Load word from 0x0006 → no mem_req, rsp_exc=01 one cycle after acceptance; repeat as a store → rsp_exc=10.
- DATA_W=64, load doubleword from 0x10 with ack after 5 WAIT cycles → stall high for 6 cycles, rsp_rdata = mem_rdata unchanged; load byte-unsigned from 0x17 with mem_rdata=0xC3xx..xx → rsp_rdata=0xC3.
- TIMEOUT=4, never ack → mem_req high 5 cycles, rsp_valid with rsp_exc=11 at t+6; the next request is accepted at t+7.
- Assert reset during WAIT → mem_req=0 and IDLE on the next cycle, no rsp_valid; a new request afterwards completes normally.
